hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. Drives the stall and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Three causes are handled: load-use hazards, multi-cycle EX operations such as the divider, and branch or jump redirects resolved in EX. The block sits beside the pipeline registers; each register consumes its stall and flush pair.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_load_use_det.sv | 34 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline sequencing controller: FSM state
// encoding, default multi-cycle occupancy, register address type and the
// constants used when a pipeline register is loaded with a bubble.
package hazard_ctrl_pkg;

    // FSM state encoding
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MC_WAIT = 1'b1;

    // Default EX occupancy of a multi-cycle op (divider), in cycles
    localparam int MC_CYCLES_DEF = 32;

    // Register file address bus
    typedef logic [4:0] RegAddrBus;

    // Bubble constants: x0 as destination, zero data
    localparam RegAddrBus   NopRegAddr = 5'd0;
    localparam logic [31:0] Zero       = 32'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_det.sv
// load_use_det
// Purely combinational load-use hazard detector. Flags when the instruction
// in ID reads the destination of a load currently in EX. Writes to x0 are
// never a hazard.
// Ports:
//   id_rs1, id_rs2        source addresses of the ID instruction
//   id_rs1_re, id_rs2_re  the corresponding source is actually read
//   ex_rd                 destination of the EX instruction
//   ex_regwe              EX instruction writes ex_rd
//   ex_is_load            EX instruction is a load
//   hit                   load-use hazard present this cycle
module load_use_det
    import hazard_ctrl_pkg::*;
(
    input  RegAddrBus id_rs1,
    input  RegAddrBus id_rs2,
    input  logic      id_rs1_re,
    input  logic      id_rs2_re,
    input  RegAddrBus ex_rd,
    input  logic      ex_regwe,
    input  logic      ex_is_load,
    output logic      hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_re && (id_rs1 == ex_rd);
    assign rs2_match = id_rs2_re && (id_rs2 == ex_rd);

    assign hit = ex_is_load && ex_regwe && (ex_rd != NopRegAddr)
                 && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the five-stage core. Produces stall and
// flush controls for PC, IF/ID, ID/EX and EX/MEM from three causes: EX
// redirects, multi-cycle EX ops and load-use hazards.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_rs1/id_rs2, *_re          ID source addresses and read enables
//   ex_rd, ex_regwe, ex_is_load  EX destination info
//   ex_mc_start                  multi-cycle op sitting in EX (level)
//   ex_redirect                  taken branch/jump resolved in EX
//   stall_pc/if_id/id_ex         hold the register
//   flush_if_id/id_ex/ex_mem     load a bubble into the register
//   mc_busy                      FSM is waiting on a multi-cycle op
//   mc_done                      one-cycle pulse on multi-cycle release
//   bubble_cnt                   cycles with any flush asserted (wraps)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = MC_CYCLES_DEF,
    parameter int CNT_W     = $clog2(MC_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_re,
    input  logic        id_rs2_re,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwe,
    input  logic        ex_is_load,
    input  logic        ex_mc_start,
    input  logic        ex_redirect,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [31:0] bubble_cnt
);

    // The start cycle itself is one of the MC_CYCLES-1 stall cycles, so the
    // wait state counts down the remaining MC_CYCLES-2 before releasing.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu_hit;
    logic             any_flush;

    load_use_det u_load_use_det (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_re  (id_rs1_re),
        .id_rs2_re  (id_rs2_re),
        .ex_rd      (ex_rd),
        .ex_regwe   (ex_regwe),
        .ex_is_load (ex_is_load),
        .hit        (lu_hit)
    );

    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        mc_busy      = 1'b0;
        mc_done      = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        // Kill the two wrong-path instructions; a multi-cycle
                        // op on the same cycle is itself being squashed.
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (ex_mc_start) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        cnt_nxt      = CNT_LOAD;
                        state_nxt    = MC_WAIT;
                    end else if (lu_hit) begin
                        // One bubble: next cycle the load is in MEM and the
                        // bypass path supplies the operand.
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
                MC_WAIT: begin
                    mc_busy = 1'b1;
                    // EX is occupied: redirect and load-use cannot arise here.
                    if (cnt != '0) begin
                        stall_pc     = 1'b1;
                        stall_if_id  = 1'b1;
                        stall_id_ex  = 1'b1;
                        flush_ex_mem = 1'b1;
                        cnt_nxt      = cnt - 1'b1;
                    end else begin
                        mc_done   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign any_flush = flush_if_id | flush_id_ex | flush_ex_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            bubble_cnt <= Zero;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (any_flush) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int MC = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_re;
        logic       rs2_re;
        logic [4:0] rd;
        logic       regwe;
        logic       is_load;
        logic       mc_start;
        logic       redirect;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp; // {spc,sif,sid,fif,fid,fem,busy,done}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_rs1_re = 0, id_rs2_re = 0, ex_regwe = 0, ex_is_load = 0;
    logic        ex_mc_start = 0, ex_redirect = 0;
    logic        stall_pc, stall_if_id, stall_id_ex;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, mc_busy, mc_done;
    logic [31:0] bubble_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: position of the current cycle within a multi-cycle
    // op (0 = none, 2..MC = waiting cycles) and the bubble tally.
    int          m_age = 0;
    logic [31:0] m_bub = '0;
    bit          m_bub_known = 0;

    hazard_ctrl #(.MC_CYCLES(MC)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
        .ex_rd(ex_rd), .ex_regwe(ex_regwe), .ex_is_load(ex_is_load),
        .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .mc_busy(mc_busy), .mc_done(mc_done), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    // Apply one cycle of inputs, check against the model at the negedge,
    // then advance the model across the posedge. Returns the control vector.
    task automatic cycle(input logic r, input in_t v, input string name, output logic [7:0] act);
        logic [7:0] exp;
        logic       lu;
        int         nxt_age;
        rst = r;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_re = v.rs1_re; id_rs2_re = v.rs2_re;
        ex_rd = v.rd; ex_regwe = v.regwe; ex_is_load = v.is_load;
        ex_mc_start = v.mc_start; ex_redirect = v.redirect;
        @(negedge clk);
        lu = v.is_load && v.regwe && (v.rd != 0) &&
             ((v.rs1_re && v.rs1 == v.rd) || (v.rs2_re && v.rs2 == v.rd));
        exp = 8'h00;
        nxt_age = m_age;
        if (r) begin
            nxt_age = 0;
        end else if (m_age == 0) begin
            if (v.redirect)      exp = 8'b0001_1000;
            else if (v.mc_start) begin exp = 8'b1110_0100; nxt_age = 2; end
            else if (lu)         exp = 8'b1100_1000;
        end else if (m_age < MC) begin
            exp = 8'b1110_0110;
            nxt_age = m_age + 1;
        end else begin
            exp = 8'b0000_0011;
            nxt_age = 0;
        end
        act = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
               flush_ex_mem, mc_busy, mc_done};
        check({name, " ctrl"}, {24'd0, act}, {24'd0, exp});
        if (m_bub_known) check({name, " bubble_cnt"}, bubble_cnt, m_bub);
        @(posedge clk);
        m_age = nxt_age;
        if (r) begin
            m_bub = '0;
            m_bub_known = 1;
        end else if (exp[4] | exp[3] | exp[2]) begin
            m_bub = m_bub + 1;
        end
        #1;
    endtask

    in_t        v;
    logic [7:0] a;
    vec_t       tbl[$];

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        cycle(1'b1, idle(), "reset", a);
        check("reset outputs", {24'd0, a}, 32'd0);
        cycle(1'b0, idle(), "post_reset", a);
        check("bubble after reset", bubble_cnt, 32'd0);

        // Single-cycle RUN-state vectors
        tbl.push_back('{"lu_rs2",      '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0}, 8'b1100_1000});
        tbl.push_back('{"lu_rs1",      '{5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0}, 8'b1100_1000});
        tbl.push_back('{"lu_rd0",      '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0}, 8'b0000_0000});
        tbl.push_back('{"lu_re0",      '{5'd1, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0}, 8'b0000_0000});
        tbl.push_back('{"lu_noload",   '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0}, 8'b0000_0000});
        tbl.push_back('{"lu_nowe",     '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0}, 8'b0000_0000});
        tbl.push_back('{"lu_mismatch", '{5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0}, 8'b0000_0000});
        tbl.push_back('{"redir_mc",    '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1}, 8'b0001_1000});
        tbl.push_back('{"redir_lu",    '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1}, 8'b0001_1000});
        tbl.push_back('{"after_redir", '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 8'b0000_0000});
        foreach (tbl[i]) begin
            cycle(1'b0, tbl[i].in, tbl[i].name, a);
            check({"table ", tbl[i].name}, {24'd0, a}, {24'd0, tbl[i].exp});
        end

        // Load-use sequence: one bubble, then clear
        cycle(1'b1, idle(), "lu_rst", a);
        v = idle(); v.is_load = 1; v.regwe = 1; v.rd = 5; v.rs2 = 5; v.rs2_re = 1;
        cycle(1'b0, v, "lu_seq1", a);
        check("lu_seq hit", {24'd0, a}, 32'b1100_1000);
        cycle(1'b0, idle(), "lu_seq2", a);
        check("lu_seq clear", {24'd0, a}, 32'd0);
        check("lu_seq bubble_cnt", bubble_cnt, 32'd1);

        // Multi-cycle op held for MC cycles
        cycle(1'b1, idle(), "mc_rst", a);
        v = idle(); v.mc_start = 1;
        cycle(1'b0, v, "mc_c1", a); check("mc c1", {24'd0, a}, 32'b1110_0100);
        cycle(1'b0, v, "mc_c2", a); check("mc c2", {24'd0, a}, 32'b1110_0110);
        cycle(1'b0, v, "mc_c3", a); check("mc c3", {24'd0, a}, 32'b1110_0110);
        cycle(1'b0, v, "mc_c4", a); check("mc c4 release", {24'd0, a}, 32'b0000_0011);
        cycle(1'b0, idle(), "mc_c5", a); check("mc c5 idle", {24'd0, a}, 32'd0);
        check("mc bubble_cnt", bubble_cnt, 32'd3);

        // Redirect during MC_WAIT (cnt=2) is ignored
        v = idle(); v.mc_start = 1;
        cycle(1'b0, v, "mcr_c1", a);
        v.redirect = 1;
        cycle(1'b0, v, "mcr_c2", a); check("mcr c2 ignore redirect", {24'd0, a}, 32'b1110_0110);
        v.redirect = 0;
        cycle(1'b0, v, "mcr_c3", a); check("mcr c3", {24'd0, a}, 32'b1110_0110);
        cycle(1'b0, v, "mcr_c4", a); check("mcr c4 release", {24'd0, a}, 32'b0000_0011);
        cycle(1'b0, idle(), "mcr_c5", a);

        // Reset mid MC_WAIT: outputs drop, no mc_done afterwards
        v = idle(); v.mc_start = 1;
        cycle(1'b0, v, "mcx_c1", a);
        cycle(1'b0, v, "mcx_c2", a);
        cycle(1'b1, idle(), "mcx_rst", a); check("mcx rst outputs", {24'd0, a}, 32'd0);
        cycle(1'b0, idle(), "mcx_c4", a); check("mcx no done", {24'd0, a}, 32'd0);
        cycle(1'b0, idle(), "mcx_c5", a); check("mcx still idle", {24'd0, a}, 32'd0);
        check("mcx bubble_cnt", bubble_cnt, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v.rs1      = 5'($urandom_range(0, 3));
            v.rs2      = 5'($urandom_range(0, 3));
            v.rs1_re   = 1'($urandom_range(0, 1));
            v.rs2_re   = 1'($urandom_range(0, 1));
            v.rd       = 5'($urandom_range(0, 3));
            v.regwe    = 1'($urandom_range(0, 3) != 0);
            v.is_load  = 1'($urandom_range(0, 1));
            v.mc_start = 1'(m_age != 0 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 7) == 0);
            v.redirect = 1'($urandom_range(0, 5) == 0);
            cycle(1'($urandom_range(0, 99) == 0), v, "rand", a);
            check("rand stall/flush exclusive",
                  {31'd0, (a[6] & a[4]) | (a[5] & a[3])}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
